datamem_arbiter: RTL
====================

Name: datamem_arbiter

Overview:
Arbitrates the single-port data memory between the CPU data port and a DMA/peripheral requester. Each requester uses a req/ack handshake with separate read and write data. The block sequences one memory access at a time and drives the memory command, address and data-line enable. It sits between the cpu/DMA blocks and datamemory; the top-level testbench instantiates it in place of the direct cpu-to-datamemory wiring.

Parameters:
ADDR_W, 8, address width of data memory
DATA_W, 8, data width of data memory
WAIT_CYCLES, 0, extra memory wait states inserted per access (0..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request; held with cpu_we/addr/wdata stable until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  read data, valid in the cycle cpu_ack=1
cpu_ack  out  1  one-cycle completion pulse
dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack  same as cpu_* for the DMA requester
mem_cmd  out  8  memory command: CMD_IDLE 8'h00, CMD_RD 8'h01, CMD_WR 8'h02
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  value to drive onto data_line
mem_oe  out  1  1 = drive mem_wdata onto data_line (top-level tristate)
mem_rdata  in  DATA_W  data_line as sampled
owner  out  1  0 = CPU, 1 = DMA; meaningful while busy=1
busy  out  1  access in progress

Behaviour:
- Reset: state=IDLE; mem_cmd=CMD_IDLE; mem_addr=0; mem_wdata=0; mem_oe=0; cpu_ack=dma_ack=0; cpu_rdata=dma_rdata=0; owner=0; busy=0; rr_last=1, so the CPU wins the first tie.
- FSM has states IDLE, ACCESS, WAIT, DONE. All outputs are registered.
- IDLE: if any req=1, choose the winner. With a single requester, that requester wins. With both requesting, round-robin selects the requester not equal to rr_last. Latch winner address, write-enable and write data. Set owner, busy=1. Next state is ACCESS. Otherwise stay in IDLE with mem_cmd=CMD_IDLE.
- ACCESS: mem_cmd is CMD_WR or CMD_RD; mem_addr is the latched address; mem_oe=1 only for writes. Next state is WAIT if WAIT_CYCLES>0 (load counter to WAIT_CYCLES-1), else DONE.
- WAIT: hold the mem outputs; decrement the counter. At 0, next state is DONE.
- DONE: for reads, capture mem_rdata into the winner's rdata. Pulse the winner's ack for exactly one cycle. Set mem_cmd=CMD_IDLE, mem_oe=0, rr_last=owner, busy=0. Next state is IDLE.
- Latency with WAIT_CYCLES=0: req sampled in IDLE at cycle N; memory command in N+1; ack in N+2. Back-to-back throughput is one access per 3 cycles.
- Non-winner rdata holds its previous value. Loser ack stays 0.
- Requester deasserts req in the cycle after ack. If req is still high in IDLE after ack, it is treated as a new request.
- Req dropped mid-access (protocol violation): the access completes anyway and ack still pulses.
- Both reqs continuously high: grants strictly alternate CPU, DMA, CPU, ...
- Async reset mid-access: all outputs return to reset values immediately. Any in-flight write may or may not have reached memory; no ack is issued.
- mem_oe and mem_cmd=CMD_WR are never asserted in the same cycle as an ack.

Optional Feature:
ARB_CPU_PRIO_EN
- Defined: fixed priority. The CPU always wins ties, rr_last is unused, and DMA can starve under continuous CPU load.
- Undefined: round-robin as above.

Decomposition:
- Package datamem_pkg holds CMD_IDLE/CMD_RD/CMD_WR localparams, the state enum encoding (IDLE=0, ACCESS=1, WAIT=2, DONE=3) and OWNER_CPU/OWNER_DMA constants.
- One sub-module, arb_rr2: 2-way grant logic with inputs req[1:0] and last, output grant index. Its prio macro behaviour lives there.

Test Plan:
- CPU write alone: cpu_req=1, we=1, addr=8'h10, wdata=8'hA5 -> mem_cmd=8'h02, mem_addr=8'h10, mem_oe=1 at N+1; cpu_ack at N+2; a later CPU read of 8'h10 returns 8'hA5.
- DMA read alone: memory holds 8'h3C at 8'h20 -> dma_rdata=8'h3C with dma_ack at N+2; cpu_ack stays 0.
- Simultaneous reqs held high for 4 grants -> owner sequence is 0,1,0,1, acks alternate; with ARB_CPU_PRIO_EN the sequence is 0,0,0,0.
- WAIT_CYCLES=3 read -> mem_cmd=CMD_RD held for 4 cycles; ack at N+5.
- rst_n pulled low during ACCESS -> mem_cmd=0, mem_oe=0, busy=0 in the same cycle; no ack; after release, the CPU wins the first tie.
- Req held after ack -> a second access starts; exactly one ack per access, never two consecutive ack cycles.

Source files
------------

// File: rtl/datamem_pkg.sv
// Shared constants for the data-memory arbiter.
// Memory command codes, FSM state encoding and owner ids.
package datamem_pkg;

  localparam logic [7:0] CMD_IDLE = 8'h00;
  localparam logic [7:0] CMD_RD   = 8'h01;
  localparam logic [7:0] CMD_WR   = 8'h02;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way grant logic: round-robin on ties, or fixed
// CPU priority when ARB_CPU_PRIO_EN is defined.
module arb_rr2
  import datamem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o
);

`ifdef ARB_CPU_PRIO_EN
  logic unused_last;
  assign unused_last = last_i;

  // CPU wins whenever it asks
  always_comb begin
    grant_o = OWNER_CPU;
    unique case (req_i)
      2'b10:   grant_o = OWNER_DMA;
      default: grant_o = OWNER_CPU;
    endcase
  end
`else
  // Ties go to whoever was not served last
  always_comb begin
    grant_o = OWNER_CPU;
    unique case (req_i)
      2'b11:   grant_o = ~last_i;
      2'b10:   grant_o = OWNER_DMA;
      default: grant_o = OWNER_CPU;
    endcase
  end
`endif

endmodule

// File: rtl/datamem_arbiter.sv
// Single-port data memory arbiter between CPU and DMA.
// ARB_CPU_PRIO_EN selects fixed CPU priority over round-robin.
module datamem_arbiter
  import datamem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [7:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
);

  localparam logic [3:0] WLOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rr_last_q, rr_last_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              oe_q, oe_d;
  logic              cack_q, cack_d;
  logic              dack_q, dack_d;
  logic [DATA_W-1:0] crd_q, crd_d;
  logic [DATA_W-1:0] drd_q, drd_d;
  logic              grant;
  logic              fin;

  arb_rr2 u_arb (
    .req_i   ({dma_req, cpu_req}),
    .last_i  (rr_last_q),
    .grant_o (grant)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_last_d = rr_last_q;
    owner_d   = owner_q;
    we_d      = we_q;
    busy_d    = busy_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    oe_d      = oe_q;
    cack_d    = 1'b0;
    dack_d    = 1'b0;
    crd_d     = crd_q;
    drd_d     = drd_q;
    fin       = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_d = CMD_IDLE;
        if (cpu_req || dma_req) begin
          owner_d = grant;
          we_d    = grant ? dma_we : cpu_we;
          addr_d  = grant ? dma_addr : cpu_addr;
          wdata_d = grant ? dma_wdata : cpu_wdata;
          cmd_d   = we_d ? CMD_WR : CMD_RD;
          oe_d    = we_d;
          busy_d  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (WAIT_CYCLES > 0) begin
          cnt_d   = WLOAD;
          state_d = WAIT;
        end else begin
          fin = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) fin = 1'b1;
        else cnt_d = cnt_q - 4'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d   = DONE;
      cmd_d     = CMD_IDLE;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
      rr_last_d = owner_q;
      if (owner_q == OWNER_DMA) begin
        dack_d = 1'b1;
        if (!we_q) drd_d = mem_rdata;
      end else begin
        cack_d = 1'b1;
        if (!we_q) crd_d = mem_rdata;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      rr_last_q <= 1'b1;
      owner_q   <= OWNER_CPU;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      cmd_q     <= CMD_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      oe_q      <= 1'b0;
      cack_q    <= 1'b0;
      dack_q    <= 1'b0;
      crd_q     <= '0;
      drd_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      oe_q      <= oe_d;
      cack_q    <= cack_d;
      dack_q    <= dack_d;
      crd_q     <= crd_d;
      drd_q     <= drd_d;
    end
  end

  assign cpu_rdata = crd_q;
  assign cpu_ack   = cack_q;
  assign dma_rdata = drd_q;
  assign dma_ack   = dack_q;
  assign mem_cmd   = cmd_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_oe    = oe_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule
